// File: rtl/em_access_ctrl.sv
// Two-requester round-robin sequencer for the external memory data port: range check, lane
// address/write-code generation, read capture. Optional EMC_SIGN_EXTEND_EN enables signed byte/half loads.
module em_access_ctrl #(
  parameter int MemSize = 49,
  parameter int AddrW   = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           req,
  input  logic [1:0]           we,
  input  logic [3:0]           size,
  input  logic [1:0]           sext,
  input  logic [2*AddrW-1:0]   addr,
  input  logic [63:0]          wdata,
  output logic [1:0]           ack,
  output logic [31:0]          rdata,
  output logic                 fault,
  output logic                 busy,
  output logic [2:0]           em_control,
  output logic [4*AddrW-1:0]   em_address,
  output logic [31:0]          em_wdata,
  input  logic [31:0]          em_read
);

  localparam int LW = AddrW + 2;
  localparam logic [LW-1:0] MEM_LIM = LW'(MemSize);

  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               win_q, win_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               sext_q, sext_d;
  logic [1:0]         ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               fault_q, fault_d;
  logic               busy_q, busy_d;
  logic [2:0]         em_control_q, em_control_d;
  logic [4*AddrW-1:0] em_address_q, em_address_d;
  logic [31:0]        em_wdata_q, em_wdata_d;

  logic               sel, sel_we, sel_sext, bad;
  logic [1:0]         sel_size;
  logic [AddrW-1:0]   sel_addr, a1, a2, a3;
  logic [31:0]        sel_wd, store_lanes, load_val;
  logic [LW-1:0]      nbytes, last;

  // Winner selection and request decode for the GRANT cycle
  always_comb begin
    sel      = (req == 2'b11) ? ~ptr_q : req[1];
    sel_we   = sel ? we[1] : we[0];
    sel_sext = sel ? sext[1] : sext[0];
    sel_size = sel ? size[3:2] : size[1:0];
    sel_addr = sel ? addr[2*AddrW-1:AddrW] : addr[AddrW-1:0];
    sel_wd   = sel ? wdata[63:32] : wdata[31:0];
    case (sel_size)
      2'd1:    nbytes = LW'(2);
      2'd2:    nbytes = LW'(4);
      default: nbytes = LW'(1);
    endcase
    last = {2'b00, sel_addr} + nbytes - LW'(1);
    bad  = (sel_size == 2'd3) || (last >= MEM_LIM);
    a1   = (sel_size == 2'd0) ? sel_addr : sel_addr + AddrW'(1);
    a2   = (sel_size == 2'd0) ? sel_addr :
           (sel_size == 2'd1) ? sel_addr + AddrW'(1) : sel_addr + AddrW'(2);
    a3   = (sel_size == 2'd0) ? sel_addr :
           (sel_size == 2'd1) ? sel_addr + AddrW'(1) : sel_addr + AddrW'(3);
    case (sel_size)
      2'd0:    store_lanes = {24'b0, sel_wd[7:0]};
      2'd1:    store_lanes = {16'b0, sel_wd[15:0]};
      default: store_lanes = sel_wd;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    load_val = {24'b0, em_read[7:0]};
      2'd1:    load_val = {16'b0, em_read[15:0]};
      default: load_val = em_read;
    endcase
`ifdef EMC_SIGN_EXTEND_EN
    if (sext_q && size_q == 2'd0) load_val[31:8] = {24{em_read[7]}};
    if (sext_q && size_q == 2'd1) load_val[31:16] = {16{em_read[15]}};
`endif
  end

`ifndef EMC_SIGN_EXTEND_EN
  logic unused_sext;
  assign unused_sext = sext_q;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    we_d         = we_q;
    size_d       = size_q;
    sext_d       = sext_q;
    ack_d        = 2'b00;
    rdata_d      = 32'b0;
    fault_d      = 1'b0;
    em_control_d = 3'd0;
    em_address_d = '0;
    em_wdata_d   = 32'b0;
    case (state_q)
      IDLE: if (|req) state_d = GRANT;
      GRANT: begin
        if (!(|req)) begin
          state_d = IDLE;
        end else begin
          win_d  = sel;
          we_d   = sel_we;
          size_d = sel_size;
          sext_d = sel_sext;
          if (bad) begin
            state_d = RESP;
            ack_d   = sel ? 2'b10 : 2'b01;
            fault_d = 1'b1;
          end else begin
            state_d      = ACCESS;
            em_address_d = {a3, a2, a1, sel_addr};
            if (sel_we) begin
              em_control_d = {1'b0, sel_size} + 3'd1;
              em_wdata_d   = store_lanes;
            end
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        ack_d   = win_q ? 2'b10 : 2'b01;
        rdata_d = we_q ? 32'b0 : load_val;
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = win_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b1;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      sext_q       <= 1'b0;
      ack_q        <= 2'b00;
      rdata_q      <= 32'b0;
      fault_q      <= 1'b0;
      busy_q       <= 1'b0;
      em_control_q <= 3'd0;
      em_address_q <= '0;
      em_wdata_q   <= 32'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      fault_q      <= fault_d;
      busy_q       <= busy_d;
      em_control_q <= em_control_d;
      em_address_q <= em_address_d;
      em_wdata_q   <= em_wdata_d;
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign fault      = fault_q;
  assign busy       = busy_q;
  assign em_control = em_control_q;
  assign em_address = em_address_q;
  assign em_wdata   = em_wdata_q;

endmodule

// File: tb/tb_em_access_ctrl.sv
// Directed bench for em_access_ctrl: stores, loads, range faults, round-robin order, reset abort.
module tb_em_access_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req, we, sext, ack;
  logic [3:0]  size;
  logic [19:0] addr;
  logic [63:0] wdata;
  logic [31:0] rdata, em_wdata, em_read;
  logic        fault, busy;
  logic [2:0]  em_control;
  logic [39:0] em_address;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  em_access_ctrl dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .fault(fault), .busy(busy),
    .em_control(em_control), .em_address(em_address), .em_wdata(em_wdata), .em_read(em_read)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int who, input logic w, input logic [1:0] sz, input logic s,
                         input logic [9:0] a, input logic [31:0] wd);
    if (who == 0) begin
      we[0] = w; size[1:0] = sz; sext[0] = s; addr[9:0] = a; wdata[31:0] = wd;
    end else begin
      we[1] = w; size[3:2] = sz; sext[1] = s; addr[19:10] = a; wdata[63:32] = wd;
    end
  endtask

  // One request; cyc counts cycles from the req cycle through the ack cycle inclusive.
  task automatic xact(input int who, input logic w, input logic [1:0] sz, input logic s,
                      input logic [9:0] a, input logic [31:0] wd,
                      output int cyc, output logic [1:0] ack_v, output logic [31:0] rd,
                      output logic flt, output logic [2:0] ctl_or, output logic [39:0] adr_seen,
                      output logic [31:0] wd_seen, output logic [1:0] ack_after);
    set_req(who, w, sz, s, a, wd);
    req[who] = 1'b1;
    cyc = 1; ack_v = 2'b00; rd = 32'h0; flt = 1'b0;
    ctl_or = 3'd0; adr_seen = 40'h0; wd_seen = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick;
      cyc++;
      ctl_or = ctl_or | em_control;
      if (em_control != 3'd0) wd_seen = em_wdata;
      if (em_address != 40'h0) adr_seen = em_address;
      if (ack != 2'b00) begin
        ack_v = ack; rd = rdata; flt = fault;
        break;
      end
    end
    req[who] = 1'b0;
    tick;
    ack_after = ack;
  endtask

  int          cyc;
  logic [1:0]  ack_v, ack_after, prev_ack;
  logic [31:0] rd, wd_seen;
  logic        flt;
  logic [2:0]  ctl_or;
  logic [39:0] adr_seen;
  logic [1:0]  order [3];
  int          n_ack;

  initial begin
    reset = 1'b1; req = 2'b00; we = 2'b00; sext = 2'b00; size = 4'h0;
    addr = 20'h0; wdata = 64'h0; em_read = 32'h0;
    tick; tick;
    check("reset_ack", ack, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_outs", {rdata, fault, em_control, em_wdata}, 0);
    check("reset_addr", em_address, 40'h0);
    reset = 1'b0;
    tick;

    // CPU word store to 40
    xact(0, 1'b1, 2'd2, 1'b0, 10'd40, 32'h04030201, cyc, ack_v, rd, flt, ctl_or, adr_seen, wd_seen, ack_after);
    check("wst_cycles", cyc, 4);
    check("wst_ack", ack_v, 2'b01);
    check("wst_fault", flt, 1'b0);
    check("wst_ctl", ctl_or, 3'd3);
    check("wst_addr", adr_seen, {10'd43, 10'd42, 10'd41, 10'd40});
    check("wst_wdata", wd_seen, 32'h04030201);
    check("wst_ack_single", ack_after, 2'b00);

    // CPU byte load from 45
    em_read = 32'hAABBCC08;
    xact(0, 1'b0, 2'd0, 1'b0, 10'd45, 32'hFFFFFFFF, cyc, ack_v, rd, flt, ctl_or, adr_seen, wd_seen, ack_after);
    check("bld_ctl", ctl_or, 3'd0);
    check("bld_addr", adr_seen, {10'd45, 10'd45, 10'd45, 10'd45});
    check("bld_rdata", rd, 32'h00000008);
    check("bld_ack", ack_v, 2'b01);

    // Signed half load from 0
    em_read = 32'hDEAD8021;
    xact(0, 1'b0, 2'd1, 1'b1, 10'd0, 32'h0, cyc, ack_v, rd, flt, ctl_or, adr_seen, wd_seen, ack_after);
`ifdef EMC_SIGN_EXTEND_EN
    check("hld_rdata", rd, 32'hFFFF8021);
`else
    check("hld_rdata", rd, 32'h00008021);
`endif
    check("hld_fault", flt, 1'b0);

    // Word load at 46 overruns the 49-byte memory
    xact(0, 1'b0, 2'd2, 1'b0, 10'd46, 32'h0, cyc, ack_v, rd, flt, ctl_or, adr_seen, wd_seen, ack_after);
    check("flt_fault", flt, 1'b1);
    check("flt_rdata", rd, 32'h0);
    check("flt_ctl", ctl_or, 3'd0);
    check("flt_cycles", cyc, 3);
    check("flt_ack", ack_v, 2'b01);

    // Word load at 45 ends exactly on the last byte
    em_read = 32'h11223344;
    xact(0, 1'b0, 2'd2, 1'b0, 10'd45, 32'h0, cyc, ack_v, rd, flt, ctl_or, adr_seen, wd_seen, ack_after);
    check("edge_fault", flt, 1'b0);
    check("edge_rdata", rd, 32'h11223344);
    check("edge_cycles", cyc, 4);

    // Reserved size faults even at a legal address
    xact(1, 1'b1, 2'd3, 1'b0, 10'd4, 32'h55, cyc, ack_v, rd, flt, ctl_or, adr_seen, wd_seen, ack_after);
    check("rsv_fault", flt, 1'b1);
    check("rsv_ack", ack_v, 2'b10);
    check("rsv_ctl", ctl_or, 3'd0);

    // Loader half store to 10
    xact(1, 1'b1, 2'd1, 1'b0, 10'd10, 32'hFFFF1234, cyc, ack_v, rd, flt, ctl_or, adr_seen, wd_seen, ack_after);
    check("lst_ack", ack_v, 2'b10);
    check("lst_ctl", ctl_or, 3'd2);
    check("lst_addr", adr_seen, {10'd11, 10'd11, 10'd11, 10'd10});
    check("lst_wdata", wd_seen, 32'h00001234);
    check("lst_rdata", rd, 32'h0);

    // Both requesters held from reset: CPU, loader, CPU
    reset = 1'b1; tick; reset = 1'b0;
    set_req(0, 1'b0, 2'd0, 1'b0, 10'd1, 32'h0);
    set_req(1, 1'b0, 2'd0, 1'b0, 10'd2, 32'h0);
    req = 2'b11;
    n_ack = 0; prev_ack = 2'b00;
    for (int i = 0; i < 30 && n_ack < 3; i++) begin
      tick;
      if (prev_ack != 2'b00) begin
        check("rr_ack_single", ack, 2'b00);
        check("rr_idle_after", busy, 1'b0);
      end
      if (ack != 2'b00) begin
        order[n_ack] = ack;
        n_ack++;
      end
      prev_ack = ack;
    end
    req = 2'b00;
    check("rr_count", n_ack, 3);
    if (n_ack == 3) begin
      check("rr_first", order[0], 2'b01);
      check("rr_second", order[1], 2'b10);
      check("rr_third", order[2], 2'b01);
    end
    tick; tick; tick; tick;

    // Reset during ACCESS of a word store
    set_req(0, 1'b1, 2'd2, 1'b0, 10'd8, 32'hCAFEF00D);
    req = 2'b01;
    tick; tick;
    check("rst_in_access_ctl", em_control, 3'd3);
    reset = 1'b1; req = 2'b00;
    tick;
    check("rst_ctl", em_control, 3'd0);
    check("rst_ack", ack, 2'b00);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (ack != 2'b00) n_ack++;
    end
    check("rst_no_ack", n_ack, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
